// File: rtl/obj_pkg.sv
// Shared types and constants for the OBJ (sprite) VRAM fetch path.
// Used by the regular row sequencer and the tile address calculator.
package obj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } obj_fetch_state_t;

  localparam int OBJ_TILE_BYTES = 32;
  localparam int OBJ_2D_STRIDE  = 32;
  localparam int OBJ_BITMAP_BIT = 14;

  // Sprite descriptor captured on the start cycle.
  typedef struct packed {
    logic [9:0] name;
    logic       bpp8;
    logic       map1d;
    logic       bitmapMode;
    logic [3:0] wTiles;
    logic [3:0] hTiles;
    logic [5:0] line;
    logic       hflip;
    logic       vflip;
  } obj_desc_t;

  // A tile row is 4 bytes at 4bpp and 8 bytes at 8bpp.
  function automatic logic [2:0] objWordsPerTile(input logic bpp8, input int busBytes);
    int rowBytes;
    rowBytes = bpp8 ? 8 : 4;
    return 3'(rowBytes / busBytes);
  endfunction

endpackage

// File: rtl/obj_tile_addr_calc.sv
// Combinational OBJ VRAM word address from tile name, tile row/column and word index.
// All arithmetic is carried at ADDR_W bits so wrap-around comes for free.
module obj_tile_addr_calc
  import obj_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int BUS_BYTES = 4,
  parameter int TX_W      = 3
) (
  input  logic [9:0]        name,
  input  logic              bpp8,
  input  logic              map_1d,
  input  logic              bitmap_mode,
  input  logic [3:0]        w_tiles,
  input  logic [2:0]        ty,
  input  logic [2:0]        r,
  input  logic [TX_W-1:0]   tx,
  input  logic [1:0]        k,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] nEff;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] rowBytes;
  logic [ADDR_W-1:0] tileNum;
  logic [ADDR_W-1:0] fullAddr;

  always_comb begin
    // 8bpp tiles in 2D mapping must start on an even tile name.
    nEff     = (bpp8 && !map_1d) ? ADDR_W'({name[9:1], 1'b0}) : ADDR_W'(name);
    step     = bpp8 ? ADDR_W'(2) : ADDR_W'(1);
    stride   = map_1d ? ADDR_W'(w_tiles) * step : ADDR_W'(OBJ_2D_STRIDE);
    rowBytes = bpp8 ? ADDR_W'(8) : ADDR_W'(4);
    tileNum  = nEff + ADDR_W'(ty) * stride + ADDR_W'(tx) * step;
    fullAddr = tileNum * ADDR_W'(OBJ_TILE_BYTES) + ADDR_W'(r) * rowBytes
             + ADDR_W'(k) * ADDR_W'(BUS_BYTES);
    addr     = bitmap_mode ? (fullAddr | (ADDR_W'(1) << OBJ_BITMAP_BIT)) : fullAddr;
  end

endmodule

// File: rtl/obj_row_fetch_seq.sv
// Walks one scanline of a regular sprite, streaming OBJ VRAM word addresses
// through a valid/ready handshake; one start yields one done (unless aborted).
module obj_row_fetch_seq
  import obj_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int BUS_BYTES = 4,
  parameter int MAX_W_T   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [9:0]        name,
  input  logic              bpp8,
  input  logic              map_1d,
  input  logic              bitmap_mode,
  input  logic [3:0]        w_tiles,
  input  logic [3:0]        h_tiles,
  input  logic [5:0]        line,
  input  logic              hflip,
  input  logic              vflip,
  output logic              busy,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        tile_x,
  output logic              last,
  output logic              done
);

  localparam int TX_W = (MAX_W_T > 1) ? $clog2(MAX_W_T) : 1;

  if (BUS_BYTES != 2 && BUS_BYTES != 4) begin : g_bad_bus_bytes
    $error("obj_row_fetch_seq: BUS_BYTES must be 2 or 4");
  end

  obj_fetch_state_t  state_q, state_d;
  obj_desc_t         desc_q, desc_d;
  logic [5:0]        row_q, row_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [1:0]        k_q, k_d;

  logic [2:0]        wpt;
  logic              kLast;
  logic [TX_W-1:0]   txFirst;
  logic [TX_W-1:0]   txFinal;
  logic              lastWord;
  logic              accept;
  logic [6:0]        rowsTotal;
  logic [5:0]        rowCalc;
  logic              outOfRange;
  logic [ADDR_W-1:0] calcAddr;

  always_comb begin
    wpt        = objWordsPerTile(desc_q.bpp8, BUS_BYTES);
    kLast      = ({1'b0, k_q} == (wpt - 3'd1));
    txFirst    = desc_q.hflip ? TX_W'(desc_q.wTiles - 4'd1) : '0;
    txFinal    = desc_q.hflip ? '0 : TX_W'(desc_q.wTiles - 4'd1);
    lastWord   = (state_q == EMIT) && kLast && (tx_q == txFinal);
    accept     = (state_q == EMIT) && addr_ready;
    rowsTotal  = {desc_q.hTiles, 3'b000};
    rowCalc    = desc_q.vflip ? 6'(rowsTotal - 7'd1 - {1'b0, desc_q.line}) : desc_q.line;
    // Widths beyond MAX_W_T would overflow the tile counter, so they are skipped like empty sprites.
    outOfRange = ({1'b0, desc_q.line} >= rowsTotal) || (desc_q.wTiles == 4'd0)
               || (desc_q.hTiles == 4'd0) || (32'(desc_q.wTiles) > MAX_W_T);
  end

  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    row_d   = row_q;
    tx_d    = tx_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SETUP;
          desc_d  = '{name: name, bpp8: bpp8, map1d: map_1d, bitmapMode: bitmap_mode,
                      wTiles: w_tiles, hTiles: h_tiles, line: line,
                      hflip: hflip, vflip: vflip};
        end
      end
      SETUP: begin
        row_d   = rowCalc;
        tx_d    = txFirst;
        k_d     = 2'd0;
        state_d = outOfRange ? DONE : EMIT;
      end
      EMIT: begin
        if (accept) begin
          if (lastWord) begin
            state_d = DONE;
          end else if (kLast) begin
            k_d  = 2'd0;
            tx_d = desc_q.hflip ? tx_q - 1'b1 : tx_q + 1'b1;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      desc_q  <= '0;
      row_q   <= '0;
      tx_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      row_q   <= row_d;
      tx_q    <= tx_d;
      k_q     <= k_d;
    end
  end

  obj_tile_addr_calc #(
    .ADDR_W    (ADDR_W),
    .BUS_BYTES (BUS_BYTES),
    .TX_W      (TX_W)
  ) u_addr_calc (
    .name        (desc_q.name),
    .bpp8        (desc_q.bpp8),
    .map_1d      (desc_q.map1d),
    .bitmap_mode (desc_q.bitmapMode),
    .w_tiles     (desc_q.wTiles),
    .ty          (row_q[5:3]),
    .r           (row_q[2:0]),
    .tx          (tx_q),
    .k           (k_q),
    .addr        (calcAddr)
  );

  // Address-side outputs are forced to zero outside EMIT so reset/idle reads as all-zero.
  assign busy       = (state_q != IDLE);
  assign addr_valid = (state_q == EMIT);
  assign done       = (state_q == DONE);
  assign last       = lastWord;
  assign addr       = addr_valid ? calcAddr : '0;
  assign tile_x     = addr_valid ? 3'(tx_q) : 3'd0;

endmodule

// File: tb/tb_obj_row_fetch_seq.sv
// Self-checking bench for obj_row_fetch_seq: directed cases plus randomized sprites
// with random ready gaps, checked against a per-sprite expected word list.
module tb_obj_row_fetch_seq;

  localparam int ADDR_W    = 15;
  localparam int BUS_BYTES = 4;

  typedef struct packed {
    logic [9:0] name;
    logic       bpp8;
    logic       map1d;
    logic       bitmap;
    logic [3:0] w;
    logic [3:0] h;
    logic [5:0] line;
    logic       hflip;
    logic       vflip;
  } tb_desc_t;

  // {last, tile_x, addr}
  typedef logic [ADDR_W+3:0] word_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [9:0]        name;
  logic              bpp8;
  logic              map_1d;
  logic              bitmap_mode;
  logic [3:0]        w_tiles;
  logic [3:0]        h_tiles;
  logic [5:0]        line;
  logic              hflip;
  logic              vflip;
  logic              busy;
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        tile_x;
  logic              last;
  logic              done;

  int testsRun    = 0;
  int testsFailed = 0;
  word_t expQ[$];

  obj_row_fetch_seq #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES), .MAX_W_T(8)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .name(name),
    .bpp8(bpp8), .map_1d(map_1d), .bitmap_mode(bitmap_mode), .w_tiles(w_tiles),
    .h_tiles(h_tiles), .line(line), .hflip(hflip), .vflip(vflip), .busy(busy),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr), .tile_x(tile_x),
    .last(last), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: list every word of the row in delivery order, straight from the address rules.
  function automatic void buildModel(input tb_desc_t d);
    int wpt, row, ty, r, n, s, stride, tx, t, a, total, idx;
    expQ.delete();
    if (d.w == 0 || d.h == 0 || int'(d.line) >= 8 * int'(d.h)) return;
    wpt    = (d.bpp8 ? 8 : 4) / BUS_BYTES;
    row    = d.vflip ? 8 * int'(d.h) - 1 - int'(d.line) : int'(d.line);
    ty     = (row / 8) % 8;
    r      = row % 8;
    n      = (d.bpp8 && !d.map1d) ? (int'(d.name) / 2) * 2 : int'(d.name);
    s      = d.bpp8 ? 2 : 1;
    stride = d.map1d ? int'(d.w) * s : 32;
    total  = int'(d.w) * wpt;
    idx    = 0;
    for (int i = 0; i < int'(d.w); i++) begin
      tx = d.hflip ? int'(d.w) - 1 - i : i;
      t  = n + ty * stride + tx * s;
      for (int k = 0; k < wpt; k++) begin
        a = (t * 32 + r * (d.bpp8 ? 8 : 4) + k * BUS_BYTES) % (1 << ADDR_W);
        if (d.bitmap) a = a | (1 << 14);
        idx++;
        expQ.push_back({(idx == total), 3'(tx), ADDR_W'(a)});
      end
    end
  endfunction

  task automatic driveDesc(input tb_desc_t d);
    name = d.name; bpp8 = d.bpp8; map_1d = d.map1d; bitmap_mode = d.bitmap;
    w_tiles = d.w; h_tiles = d.h; line = d.line; hflip = d.hflip; vflip = d.vflip;
  endtask

  // readyMode: 0 = always ready, 1 = random gaps, 2 = stall 3 cycles on word 2.
  task automatic applyStimulus(input tb_desc_t d, input int readyMode, input bit spamStart,
                               output logic [31:0] firstAddr, output logic [31:0] lastAddr,
                               output int words);
    int  expected;
    int  cyc;
    int  stall;
    bit  gotDone;
    buildModel(d);
    expected  = expQ.size();
    firstAddr = 32'hFFFF_FFFF;
    lastAddr  = 32'hFFFF_FFFF;
    words     = 0;
    cyc       = 0;
    stall     = 0;
    gotDone   = 0;
    driveDesc(d);
    start = 1'b1;
    abort = 1'b0;
    addr_ready = 1'b0;
    @(posedge clock); #1;
    start = spamStart;
    name = 10'($urandom); w_tiles = 4'($urandom); h_tiles = 4'($urandom);
    line = 6'($urandom); bpp8 = 1'($urandom); hflip = 1'($urandom); vflip = 1'($urandom);
    checkOutput("setup_state", {busy, addr_valid, done}, 3'b100);
    @(posedge clock); #1;
    while (!gotDone && cyc < 300) begin
      case (readyMode)
        0:       addr_ready = 1'b1;
        1:       addr_ready = 1'($urandom_range(0, 1));
        default: begin
          addr_ready = !(words == 2 && stall < 3);
          if (!addr_ready) stall++;
        end
      endcase
      if (addr_valid) begin
        if (expQ.size() == 0) checkOutput("extra_word", 32'(addr_valid), 32'd0);
        else checkOutput("word", 32'({last, tile_x, addr}), 32'(expQ[0]));
        if (addr_ready) begin
          if (words == 0) firstAddr = 32'(addr);
          lastAddr = 32'(addr);
          words++;
          if (expQ.size() != 0) void'(expQ.pop_front());
        end
      end
      if (done) begin
        gotDone = 1'b1;
        checkOutput("done_after_all_words", 32'(expQ.size()), 32'd0);
        start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    addr_ready = 1'b0;
    start = 1'b0;
    if (!gotDone) checkOutput("done_timeout", 32'd0, 32'd1);
    checkOutput("idle_after_done", {busy, done, addr_valid}, 3'b000);
    if (readyMode == 0) checkOutput("bubble_free_cycles", 32'(cyc), 32'(expected + 1));
  endtask

  initial begin
    tb_desc_t d;
    logic [31:0] fa, la;
    int nw;
    bit sawDone;

    reset = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    driveDesc('0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_outputs", 32'({busy, addr_valid, last, done, tile_x, addr}), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    d = '{name: 10'd10, bpp8: 0, map1d: 1, bitmap: 0, w: 4'd2, h: 4'd2, line: 6'd9, hflip: 0, vflip: 0};
    applyStimulus(d, 0, 0, fa, la, nw);
    checkOutput("c1_first", fa, 32'd388);
    checkOutput("c1_last", la, 32'd420);
    checkOutput("c1_words", 32'(nw), 32'd2);

    d.hflip = 1;
    applyStimulus(d, 0, 0, fa, la, nw);
    checkOutput("hflip_first", fa, 32'd420);
    checkOutput("hflip_last", la, 32'd388);

    d = '{name: 10'd11, bpp8: 1, map1d: 0, bitmap: 0, w: 4'd2, h: 4'd1, line: 6'd0, hflip: 0, vflip: 0};
    applyStimulus(d, 0, 0, fa, la, nw);
    checkOutput("bpp8_first", fa, 32'd320);
    checkOutput("bpp8_last", la, 32'd388);
    checkOutput("bpp8_words", 32'(nw), 32'd4);

    d.vflip = 1; d.h = 4'd2;
    applyStimulus(d, 0, 0, fa, la, nw);
    checkOutput("vflip_first", fa, 32'd1400);
    checkOutput("vflip_last", la, 32'd1468);

    applyStimulus(d, 2, 0, fa, la, nw);
    checkOutput("stall_words", 32'(nw), 32'd4);

    d = '{name: 10'd5, bpp8: 0, map1d: 1, bitmap: 1, w: 4'd1, h: 4'd1, line: 6'd0, hflip: 0, vflip: 0};
    applyStimulus(d, 0, 0, fa, la, nw);
    checkOutput("bitmap_addr", fa, 32'd16544);

    d = '{name: 10'd1023, bpp8: 0, map1d: 1, bitmap: 0, w: 4'd2, h: 4'd1, line: 6'd0, hflip: 0, vflip: 0};
    applyStimulus(d, 0, 0, fa, la, nw);
    checkOutput("wrap_first", fa, 32'd32736);
    checkOutput("wrap_second", la, 32'd0);

    d = '{name: 10'd10, bpp8: 0, map1d: 1, bitmap: 0, w: 4'd2, h: 4'd2, line: 6'd16, hflip: 0, vflip: 0};
    applyStimulus(d, 0, 0, fa, la, nw);
    checkOutput("out_of_range_words", 32'(nw), 32'd0);

    d.line = 6'd0; d.w = 4'd0;
    applyStimulus(d, 0, 0, fa, la, nw);
    checkOutput("zero_width_words", 32'(nw), 32'd0);

    d = '{name: 10'd10, bpp8: 0, map1d: 1, bitmap: 0, w: 4'd3, h: 4'd2, line: 6'd9, hflip: 0, vflip: 1};
    applyStimulus(d, 0, 1, fa, la, nw);
    checkOutput("start_while_busy_words", 32'(nw), 32'd3);

    // Abort in the middle of a row.
    d = '{name: 10'd40, bpp8: 1, map1d: 1, bitmap: 0, w: 4'd4, h: 4'd1, line: 6'd3, hflip: 0, vflip: 0};
    driveDesc(d); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; addr_ready = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    checkOutput("abort_pre_valid", 32'(addr_valid), 32'd1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0; addr_ready = 1'b0;
    checkOutput("abort_idle", {busy, addr_valid}, 2'b00);
    sawDone = 1'b0;
    repeat (4) begin
      if (done) sawDone = 1'b1;
      @(posedge clock); #1;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);

    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("start_abort_idle", 32'(busy), 32'd0);

    // Reset in the middle of a row.
    driveDesc(d); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; addr_ready = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("reset_mid_emit", 32'({busy, addr_valid, last, done, tile_x, addr}), 32'd0);
    reset = 1'b0; addr_ready = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 40; i++) begin
      d.name   = 10'($urandom);
      d.bpp8   = 1'($urandom);
      d.map1d  = 1'($urandom);
      d.bitmap = 1'($urandom);
      d.w      = 4'($urandom_range(1, 8));
      d.h      = 4'($urandom_range(1, 8));
      d.line   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 8 * int'(d.h) - 1));
      d.hflip  = 1'($urandom);
      d.vflip  = 1'($urandom);
      applyStimulus(d, 1, 1'($urandom), fa, la, nw);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
